// File: rtl/mc_core.sv
// mc_core: multi-cycle FETCH/EXEC/MEM processor core with req/ack instruction and data memory ports.
module mc_core #(
    parameter int DATA_W = 28,
    parameter int PC_W = 12,
    parameter int RA_W = 4,
    parameter int DADDR_W = 12,
    localparam int INSTR_W = 8 + 3 * RA_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               halted,
    output logic               illegal,
    output logic               zf_out
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT_ST} state_t;
    state_t              r_state, w_next;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_rf [2**RA_W];
    logic                r_zf, r_ill, r_dwe;
    logic [DADDR_W-1:0]  r_daddr;
    logic [DATA_W-1:0]   r_dwdata;
    logic [7:0]          w_op;
    logic [RA_W-1:0]     w_dst, w_s0, w_s1;
    logic [DATA_W-1:0]   w_imm, w_rs0, w_rs1, w_alu;
    logic                w_wr, w_zupd, w_bad, w_take, w_mem, w_halt;
    assign w_op   = r_ir[INSTR_W-1 -: 8];
    assign w_dst  = r_ir[DATA_W+3*RA_W-1 -: RA_W];
    assign w_s0   = r_ir[DATA_W+2*RA_W-1 -: RA_W];
    assign w_s1   = r_ir[DATA_W+RA_W-1 -: RA_W];
    assign w_imm  = r_ir[DATA_W-1:0];
    assign w_rs0  = r_rf[w_s0];
    assign w_rs1  = r_rf[w_s1];
    assign w_mem  = (w_op == 8'h10) || (w_op == 8'h11);
    assign w_halt = w_op == 8'hFF;
    // Conditional jumps see zf as registered before this EXEC.
    assign w_take = (w_op == 8'h20) || (w_op == 8'h21 && r_zf) || (w_op == 8'h22 && !r_zf);
    assign imem_req   = !rst && r_state == FETCH;
    assign imem_addr  = r_pc;
    assign dmem_req   = !rst && r_state == MEM;
    assign dmem_we    = r_dwe;
    assign dmem_addr  = r_daddr;
    assign dmem_wdata = r_dwdata;
    assign halted     = r_state == HALT_ST;
    assign illegal    = r_ill;
    assign zf_out     = r_zf;
    always_comb begin
        w_alu  = '0;
        w_wr   = 1'b0;
        w_zupd = 1'b0;
        w_bad  = 1'b0;
        case (w_op)
            8'h01: begin w_alu = w_rs0 + w_rs1; w_wr = 1'b1; w_zupd = 1'b1; end
            8'h02: begin w_alu = w_rs0 - w_rs1; w_wr = 1'b1; w_zupd = 1'b1; end
            8'h03: begin w_alu = w_rs0 & w_rs1; w_wr = 1'b1; w_zupd = 1'b1; end
            8'h04: begin w_alu = w_rs0 | w_rs1; w_wr = 1'b1; w_zupd = 1'b1; end
            8'h05: begin w_alu = w_rs0 ^ w_rs1; w_wr = 1'b1; w_zupd = 1'b1; end
            8'h06: begin w_alu = w_imm; w_wr = 1'b1; end
            8'h07: begin w_alu = w_rs0 + w_imm; w_wr = 1'b1; w_zupd = 1'b1; end
            8'h00, 8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'hFF: ;
            default: w_bad = 1'b1;
        endcase
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:   w_next = imem_ack ? EXEC : FETCH;
            EXEC:    w_next = w_halt ? HALT_ST : w_mem ? MEM : FETCH;
            MEM:     w_next = dmem_ack ? FETCH : MEM;
            default: w_next = HALT_ST;
        endcase
    end
    always_ff @(posedge clk) begin
        r_state <= rst ? FETCH : w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_zf     <= 1'b0;
            r_ill    <= 1'b0;
            r_dwe    <= 1'b0;
            r_daddr  <= '0;
            r_dwdata <= '0;
            for (int i = 0; i < 2**RA_W; i++) r_rf[i] <= '0;
        end else begin
            if (r_state == FETCH && imem_ack) r_ir <= imem_rdata;
            if (r_state == EXEC) begin
                if (w_wr) r_rf[w_dst] <= w_alu;
                if (w_zupd) r_zf <= (w_alu == '0);
                if (w_bad) r_ill <= 1'b1;
                // Store address/data are frozen here so they stay stable for the whole MEM wait.
                if (w_mem) begin
                    r_dwe    <= w_op[0];
                    r_daddr  <= w_rs1[DADDR_W-1:0];
                    r_dwdata <= w_rs0;
                end else if (!w_halt) begin
                    r_pc <= w_take ? w_imm[PC_W-1:0] : r_pc + 1'b1;
                end
            end
            if (r_state == MEM && dmem_ack) begin
                if (!r_dwe) r_rf[w_dst] <= dmem_rdata;
                r_pc <= r_pc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: scoreboard bench with wait-state memory models; expected fetches and data accesses are queued per program.
module tb_mc_core;
    localparam int DATA_W = 28, PC_W = 12, RA_W = 4, DADDR_W = 12;
    localparam int INSTR_W = 8 + 3 * RA_W + DATA_W;
    localparam logic [INSTR_W-1:0] HALT_I = {8'hFF, {(INSTR_W-8){1'b0}}};
    typedef struct { logic we; logic [DADDR_W-1:0] addr; logic [DATA_W-1:0] data; } dm_t;
    logic clk = 0, rst = 1;
    logic imem_req, imem_ack = 0, dmem_req, dmem_we, dmem_ack = 0;
    logic halted, illegal, zf_out;
    logic [PC_W-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic [DADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata, dmem_rdata = '0;
    logic [INSTR_W-1:0] imem_m [0:4095];
    logic [DATA_W-1:0] dmem_m [0:4095];
    int imem_wt [0:4095];
    int fetch_cyc [0:4095];
    int req_cyc [0:4095];
    int st_wt, ld_wt, ld_req_cyc, cyc, icnt, dcnt;
    int n_checks = 0, n_errors = 0;
    logic [PC_W-1:0] exp_fetch [$];
    dm_t exp_dm [$];
    mc_core #(.DATA_W(DATA_W), .PC_W(PC_W), .RA_W(RA_W), .DADDR_W(DADDR_W)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .halted(halted), .illegal(illegal), .zf_out(zf_out)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    function automatic logic [INSTR_W-1:0] ins(input logic [7:0] op, input int d, input int s0, input int s1,
                                               input logic [DATA_W-1:0] imm);
        return {op, d[RA_W-1:0], s0[RA_W-1:0], s1[RA_W-1:0], imm};
    endfunction
    // Memory responders: decide ack on the falling edge so it is stable at the next rising edge.
    always @(negedge clk) begin
        if (imem_req) begin
            if (icnt >= imem_wt[imem_addr]) begin
                imem_ack = 1; imem_rdata = imem_m[imem_addr]; icnt = 0;
            end else begin
                imem_ack = 0; imem_rdata = '0; icnt++;
            end
        end else begin
            imem_ack = 0; imem_rdata = '0; icnt = 0;
        end
        if (dmem_req) begin
            if (dcnt >= (dmem_we ? st_wt : ld_wt)) begin
                dmem_ack = 1; dmem_rdata = dmem_m[dmem_addr]; dcnt = 0;
            end else begin
                dmem_ack = 0; dmem_rdata = '0; dcnt++;
            end
        end else begin
            dmem_ack = 0; dmem_rdata = '0; dcnt = 0;
        end
    end
    // Monitor just before each rising edge: pops the scoreboard on every completed handshake.
    always @(negedge clk) begin
        logic [PC_W-1:0] ef;
        dm_t ed;
        #4;
        if (!rst && imem_req) req_cyc[imem_addr]++;
        if (!rst && dmem_req && !dmem_we) ld_req_cyc++;
        if (!rst && imem_req && imem_ack) begin
            fetch_cyc[imem_addr] = cyc;
            n_checks++;
            if (exp_fetch.size() == 0) begin
                n_errors++; $display("FAIL fetch_addr got %h expected none", imem_addr);
            end else begin
                ef = exp_fetch.pop_front();
                if (imem_addr !== ef) begin n_errors++; $display("FAIL fetch_addr got %h expected %h", imem_addr, ef); end
            end
        end
        if (!rst && dmem_req && dmem_ack) begin
            if (dmem_we) dmem_m[dmem_addr] = dmem_wdata;
            n_checks++;
            if (exp_dm.size() == 0) begin
                n_errors++; $display("FAIL dmem_access got we=%b addr=%h expected none", dmem_we, dmem_addr);
            end else begin
                ed = exp_dm.pop_front();
                if (dmem_we !== ed.we || dmem_addr !== ed.addr || (ed.we && dmem_wdata !== ed.data)) begin
                    n_errors++;
                    $display("FAIL dmem_access got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                             dmem_we, dmem_addr, dmem_wdata, ed.we, ed.addr, ed.data);
                end
            end
        end
    end
    task automatic hold_reset();
        @(negedge clk); #1;
        rst = 1;
        exp_fetch.delete();
        exp_dm.delete();
        for (int i = 0; i < 4096; i++) begin
            imem_m[i] = HALT_I; imem_wt[i] = 0; fetch_cyc[i] = 0; req_cyc[i] = 0;
        end
        st_wt = 0; ld_wt = 0; ld_req_cyc = 0;
    endtask
    task automatic release_reset();
        @(negedge clk); #1;
        rst = 0;
    endtask
    task automatic wait_halt(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (halted) begin ok = 1; break; end
        end
    endtask
    task automatic push_fetch(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) exp_fetch.push_back(PC_W'(a));
    endtask
    task automatic test_reset();
        bit ok;
        hold_reset();
        @(negedge clk); #2;
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL rst_imem_req got %b expected 0", imem_req); end
        n_checks++; if (dmem_req !== 1'b0) begin n_errors++; $display("FAIL rst_dmem_req got %b expected 0", dmem_req); end
        n_checks++; if ({halted, illegal, zf_out} !== 3'b000) begin n_errors++; $display("FAIL rst_flags got %b expected 000", {halted, illegal, zf_out}); end
        push_fetch(0, 0);
        release_reset();
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== '0) begin n_errors++; $display("FAIL first_fetch got req=%b addr=%h expected req=1 addr=000", imem_req, imem_addr); end
        wait_halt(20, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL reset_halt got halted=0 expected 1"); end
        n_checks++; if (exp_fetch.size() != 0) begin n_errors++; $display("FAIL reset_fetch_left got %0d expected 0", exp_fetch.size()); end
    endtask
    task automatic test_zero_wait();
        bit ok;
        hold_reset();
        imem_m[0] = ins(8'h06, 1, 0, 0, 28'd5);
        imem_m[1] = ins(8'h06, 2, 0, 0, 28'd5);
        imem_m[2] = ins(8'h02, 3, 1, 2, 28'd0);
        imem_m[3] = ins(8'h21, 0, 0, 0, 28'h010);
        imem_m[16] = ins(8'h11, 0, 3, 1, 28'd0);
        imem_m[17] = HALT_I;
        push_fetch(0, 3);
        push_fetch(16, 17);
        exp_dm.push_back('{we: 1'b1, addr: 12'h005, data: 28'h0});
        release_reset();
        wait_halt(100, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL zw_halt got halted=0 expected 1"); end
        n_checks++; if (zf_out !== 1'b1) begin n_errors++; $display("FAIL zw_zf got %b expected 1", zf_out); end
        n_checks++; if (fetch_cyc[3] - fetch_cyc[2] != 2) begin n_errors++; $display("FAIL zw_sub_cpi got %0d expected 2", fetch_cyc[3] - fetch_cyc[2]); end
        n_checks++; if (fetch_cyc[17] - fetch_cyc[16] != 3) begin n_errors++; $display("FAIL zw_st_cpi got %0d expected 3", fetch_cyc[17] - fetch_cyc[16]); end
        n_checks++; if (exp_fetch.size() + exp_dm.size() != 0) begin n_errors++; $display("FAIL zw_left got %0d expected 0", exp_fetch.size() + exp_dm.size()); end
    endtask
    task automatic test_wait_fetch();
        bit ok;
        hold_reset();
        imem_m[0] = ins(8'h06, 1, 0, 0, 28'd7);
        imem_m[1] = ins(8'h06, 2, 0, 0, 28'd9);
        imem_m[2] = ins(8'h01, 5, 1, 2, 28'd0);
        imem_m[3] = ins(8'h11, 0, 5, 2, 28'd0);
        imem_wt[2] = 3;
        push_fetch(0, 4);
        exp_dm.push_back('{we: 1'b1, addr: 12'h009, data: 28'd16});
        release_reset();
        wait_halt(100, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL wf_halt got halted=0 expected 1"); end
        n_checks++; if (req_cyc[2] != 4) begin n_errors++; $display("FAIL wf_req_held got %0d expected 4", req_cyc[2]); end
        n_checks++; if (fetch_cyc[3] - fetch_cyc[2] != 2) begin n_errors++; $display("FAIL wf_add_cpi got %0d expected 2", fetch_cyc[3] - fetch_cyc[2]); end
        n_checks++; if (zf_out !== 1'b0) begin n_errors++; $display("FAIL wf_zf got %b expected 0", zf_out); end
        n_checks++; if (exp_fetch.size() + exp_dm.size() != 0) begin n_errors++; $display("FAIL wf_left got %0d expected 0", exp_fetch.size() + exp_dm.size()); end
    endtask
    task automatic test_ldst();
        bit ok;
        hold_reset();
        ld_wt = 2;
        imem_m[0] = ins(8'h06, 1, 0, 0, 28'h0ABCDEF);
        imem_m[1] = ins(8'h06, 2, 0, 0, 28'h3FF);
        imem_m[2] = ins(8'h02, 7, 1, 1, 28'd0);
        imem_m[3] = ins(8'h11, 0, 1, 2, 28'd0);
        imem_m[4] = ins(8'h10, 4, 0, 2, 28'd0);
        imem_m[5] = ins(8'h11, 0, 4, 0, 28'd0);
        push_fetch(0, 6);
        exp_dm.push_back('{we: 1'b1, addr: 12'h3FF, data: 28'h0ABCDEF});
        exp_dm.push_back('{we: 1'b0, addr: 12'h3FF, data: 28'h0});
        exp_dm.push_back('{we: 1'b1, addr: 12'h000, data: 28'h0ABCDEF});
        release_reset();
        wait_halt(100, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL ls_halt got halted=0 expected 1"); end
        n_checks++; if (ld_req_cyc != 3) begin n_errors++; $display("FAIL ls_ld_req_held got %0d expected 3", ld_req_cyc); end
        n_checks++; if (fetch_cyc[5] - fetch_cyc[4] != 5) begin n_errors++; $display("FAIL ls_ld_cpi got %0d expected 5", fetch_cyc[5] - fetch_cyc[4]); end
        n_checks++; if (zf_out !== 1'b1) begin n_errors++; $display("FAIL ls_zf got %b expected 1", zf_out); end
        n_checks++; if (exp_fetch.size() + exp_dm.size() != 0) begin n_errors++; $display("FAIL ls_left got %0d expected 0", exp_fetch.size() + exp_dm.size()); end
    endtask
    task automatic test_modular();
        bit ok;
        hold_reset();
        imem_m[0]     = ins(8'h22, 0, 0, 0, 28'h100);
        imem_m[1]     = HALT_I;
        imem_m[256]   = ins(8'h06, 1, 0, 0, 28'hFFFFFFF);
        imem_m[257]   = ins(8'h07, 1, 1, 0, 28'd1);
        imem_m[258]   = ins(8'h06, 2, 0, 0, 28'd5);
        imem_m[259]   = ins(8'h11, 0, 1, 2, 28'd0);
        imem_m[260]   = ins(8'h20, 0, 0, 0, 28'hFFF);
        imem_m[4095]  = ins(8'h00, 0, 0, 0, 28'd0);
        push_fetch(0, 0);
        push_fetch(256, 260);
        push_fetch(4095, 4095);
        push_fetch(0, 1);
        exp_dm.push_back('{we: 1'b1, addr: 12'h005, data: 28'h0});
        release_reset();
        wait_halt(200, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL mod_halt got halted=0 expected 1"); end
        n_checks++; if (zf_out !== 1'b1) begin n_errors++; $display("FAIL mod_zf got %b expected 1", zf_out); end
        n_checks++; if (exp_fetch.size() + exp_dm.size() != 0) begin n_errors++; $display("FAIL mod_left got %0d expected 0", exp_fetch.size() + exp_dm.size()); end
    endtask
    task automatic test_illegal_halt();
        bit ok;
        int stray;
        hold_reset();
        imem_m[0] = ins(8'h55, 1, 0, 0, 28'd123);
        imem_m[1] = ins(8'h06, 2, 0, 0, 28'd9);
        imem_m[2] = ins(8'h11, 0, 1, 2, 28'd0);
        push_fetch(0, 3);
        exp_dm.push_back('{we: 1'b1, addr: 12'h009, data: 28'h0});
        release_reset();
        wait_halt(100, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL ih_halt got halted=0 expected 1"); end
        n_checks++; if (illegal !== 1'b1) begin n_errors++; $display("FAIL ih_illegal got %b expected 1", illegal); end
        n_checks++; if (imem_addr !== 12'h003) begin n_errors++; $display("FAIL ih_pc_held got %h expected 003", imem_addr); end
        stray = 0;
        repeat (8) begin @(negedge clk); #2; if (imem_req || dmem_req || !halted) stray++; end
        n_checks++; if (stray != 0) begin n_errors++; $display("FAIL ih_no_req got %0d stray cycles expected 0", stray); end
        n_checks++; if (illegal !== 1'b1) begin n_errors++; $display("FAIL ih_sticky got %b expected 1", illegal); end
        n_checks++; if (exp_fetch.size() + exp_dm.size() != 0) begin n_errors++; $display("FAIL ih_left got %0d expected 0", exp_fetch.size() + exp_dm.size()); end
    endtask
    task automatic test_reset_mid_mem();
        bit ok, hit;
        hold_reset();
        st_wt = 3;
        imem_m[0] = ins(8'h06, 1, 0, 0, 28'h77);
        imem_m[1] = ins(8'h06, 2, 0, 0, 28'h20);
        imem_m[2] = ins(8'h55, 0, 0, 0, 28'd0);
        imem_m[3] = ins(8'h11, 0, 1, 2, 28'd0);
        push_fetch(0, 3);
        release_reset();
        hit = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (dmem_req && dmem_ack) begin hit = 1; break; end
        end
        rst = 1;
        n_checks++; if (!hit) begin n_errors++; $display("FAIL rm_reach_mem got 0 expected 1"); end
        #1;
        n_checks++; if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin n_errors++; $display("FAIL rm_req_in_rst got d=%b i=%b expected 0 0", dmem_req, imem_req); end
        @(negedge clk); #2;
        n_checks++; if (illegal !== 1'b0 || halted !== 1'b0 || imem_addr !== '0) begin n_errors++; $display("FAIL rm_after_rst got ill=%b halt=%b pc=%h expected 0 0 000", illegal, halted, imem_addr); end
        st_wt = 0;
        imem_m[3] = HALT_I;
        push_fetch(0, 3);
        release_reset();
        wait_halt(100, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL rm_halt got halted=0 expected 1"); end
        n_checks++; if (illegal !== 1'b1) begin n_errors++; $display("FAIL rm_illegal_again got %b expected 1", illegal); end
        n_checks++; if (exp_fetch.size() + exp_dm.size() != 0) begin n_errors++; $display("FAIL rm_left got %0d expected 0", exp_fetch.size() + exp_dm.size()); end
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
    initial begin
        test_reset();
        test_zero_wait();
        test_wait_fetch();
        test_ldst();
        test_modular();
        test_illegal_halt();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mc_core.md
# mc_core

Parametrised multi-cycle successor to the single-cycle 28-bit processor top level. Runs the same register-register / immediate ISA style through a FETCH/EXEC/MEM state machine. Instruction and data memories sit outside the core behind req/ack handshakes, so the core tolerates wait-state memories. Adds HALT, sticky illegal-opcode reporting and configurable widths and register count.

## Interface
- DATA_W, 28, datapath, register and immediate width
- PC_W, 12, program counter width; imem word address
- RA_W, 4, register address width; register file holds 2**RA_W registers
- DADDR_W, 12, data memory word address width (≤ DATA_W)
- INSTR_W, 8+3*RA_W+DATA_W, derived, not overridable
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- imem_req  output  1  instruction fetch request
- imem_addr  output  PC_W  fetch address (= pc)
- imem_ack  input  1  fetch complete this cycle
- imem_rdata  input  INSTR_W  instruction; valid when imem_ack=1
- dmem_req  output  1  data access request
- dmem_we  output  1  1 = store, 0 = load
- dmem_addr  output  DADDR_W  = rs1[DADDR_W-1:0]
- dmem_wdata  output  DATA_W  = rs0 value
- dmem_ack  input  1  data access complete this cycle
- dmem_rdata  input  DATA_W  load data; valid when dmem_ack=1
- halted  output  1  core stopped on HALT
- illegal  output  1  sticky; set on an undefined opcode
- zf_out  output  1  zero flag

## Operation
- Instruction fields, MSB first: op[7:0], dst[RA_W], src0[RA_W], src1[RA_W], imm[DATA_W].
- Opcodes:
  - 0x00 NOP
  - 0x01 ADD rd=rs0+rs1
  - 0x02 SUB rd=rs0-rs1
  - 0x03 AND
  - 0x04 OR
  - 0x05 XOR
  - 0x06 MOVI rd=imm
  - 0x07 ADDI rd=rs0+imm
  - 0x10 LD rd=dmem[rs1]
  - 0x11 ST dmem[rs1]=rs0
  - 0x20 JMP pc=imm[PC_W-1:0]
  - 0x21 JZ: jump if zf=1
  - 0x22 JNZ: jump if zf=0
  - 0xFF HALT
- Any other opcode executes as NOP and sets illegal.
- Arithmetic is modular DATA_W; no carry or overflow is kept.
- zf = (result==0). Updated only by 0x01–0x05 and 0x07. MOVI, LD, ST and jumps leave it unchanged.
- Register file: all registers are general purpose, none hardwired. Written only in EXEC (ALU ops) or on MEM completion (LD).
- PC increments by 1 modulo 2**PC_W. Taken jumps load the target instead.
- States:
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch imem_rdata → EXEC.
  - EXEC: decode and execute.
    - ALU/MOVI/NOP/illegal: write back, pc+1 → FETCH.
    - JMP/JZ/JNZ: update pc → FETCH.
    - LD/ST: → MEM.
    - HALT: → HALT_ST, pc unchanged.
  - MEM: dmem_req=1 with dmem_we/addr/wdata held stable. On dmem_ack: LD writes rd=dmem_rdata, pc+1 → FETCH.
  - HALT_ST: halted=1, no requests. Only rst exits.
- Register read operands are sampled in EXEC. Store data and address are latched at EXEC exit.

## Timing
- Reset values:
  - state=FETCH, pc=0, all registers 0, zf_out=0, illegal=0, halted=0.
  - imem_req and dmem_req are 0 during the rst cycle.
  - imem_req=1 on the first cycle after rst deasserts.
- Handshake:
  - req stays high with address and data stable until the first rising edge where ack=1.
  - ack may be high in the same cycle req rises, giving zero wait states.
  - ack while req=0 is ignored.
  - req drops the cycle after completion unless the next state issues a new request.
- Zero-wait CPI:
  - ALU, jump, NOP: 2 cycles.
  - LD/ST: 3 cycles.
  - Each wait cycle adds 1.
- Result visibility: ALU results and zf are visible to the next instruction's EXEC. No forwarding hazards exist.
- A conditional jump uses zf as registered before its own EXEC.
- Reset mid-transaction: state is forced to FETCH and requests go low on the next edge. A late ack is ignored and no register or memory write occurs.
- PC wrap: pc=2**PC_W-1 followed by a non-jump gives pc=0.
- illegal stays set until rst.

## Test plan
- Zero-wait program MOVI r1,5; MOVI r2,5; SUB r3,r1,r2; JZ 0x010 → r3=0, zf_out=1, next imem_addr=0x010, SUB takes exactly 2 cycles.
- Wait-state fetch: imem_ack delayed 3 cycles on ADD → imem_req and imem_addr held 4 cycles, no register change until ack, result correct.
- Load/store round trip: ST r1(=0x0ABCDEF) to addr r2=0x3FF, then LD r4 from 0x3FF with dmem_ack delayed 2 cycles → dmem_we=1 then 0, r4=0x0ABCDEF, zf unchanged.
- Modular arithmetic and wrap:
  - ADDI r1=0xFFFFFFF + 1 → r1=0, zf=1.
  - pc at 0xFFF on NOP → next fetch addr 0x000.
- Illegal, HALT and reset:
  - op 0x55 → illegal=1, executes as NOP.
  - HALT → halted=1, no further req.
  - rst asserted during a MEM wait → no write, pc=0, illegal=0, fetch restarts at 0.
